// File: rtl/telemetry_framer_pkg.sv
// Shared definitions for the telemetry framer: FSM encoding, default sync byte
// and the frame length helper.
package telemetry_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_MASK,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // SYNC + SEQ + MASK + CSUM around the payload bytes.
  function automatic int frame_len(input int n_ch, input int data_w);
    return 4 + (n_ch * data_w) / 8;
  endfunction

endpackage

// File: rtl/telemetry_framer_if.sv
// Byte stream towards the UART transmitter: valid/ready, one byte per transfer.
interface telemetry_framer_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/telemetry_framer_period_tick.sv
// Free-running period divider: one-cycle tick on the last count while en=1.
// en=0 holds the counter at zero so the next period starts cleanly.
module period_tick #(
  parameter int PERIOD_CLKS = 12000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/telemetry_framer.sv
// Periodic/forced telemetry frame source: SYNC, SEQ, MASK, payload, XOR checksum.
// Each byte is followed by one idle cycle after acceptance, so at most one byte per 2 clocks.
module telemetry_framer
  import telemetry_framer_pkg::*;
#(
  parameter int          PERIOD_CLKS = 12000000,
  parameter int          N_CH        = 2,
  parameter int          DATA_W      = 16,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   force_tx,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  telemetry_framer_if.master     tx,
  output logic                   busy,
  output logic [7:0]             frame_cnt,
  output logic                   overrun
);

  localparam int SR_W    = N_CH * DATA_W;
  localparam int N_BYTES = frame_len(N_CH, DATA_W) - 4;
  localparam int IDX_W   = $clog2(N_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_t            state;
  logic              tick;
  logic              trigger;
  logic [SR_W-1:0]   snap;
  logic [SR_W-1:0]   sr;
  logic [7:0]        seq_q;
  logic [7:0]        mask_q;
  logic [7:0]        csum;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;

  period_tick #(.PERIOD_CLKS(PERIOD_CLKS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign trigger  = tick || force_tx;
  assign tx.data  = tx_data_q;
  assign tx.valid = tx_valid_q;

  // Reorder channels so ch0 sits at the top of the shift register and leaves first.
  always_comb begin
    snap = '0;
    for (int i = 0; i < N_CH; i++) begin
      snap[(N_CH-1-i)*DATA_W +: DATA_W] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
      sr         <= '0;
      seq_q      <= '0;
      mask_q     <= '0;
      csum       <= '0;
      idx        <= '0;
    end else begin
      // busy is still high in the CSUM acceptance cycle, so that trigger is dropped too.
      overrun <= trigger && busy;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            sr         <= snap;
            seq_q      <= frame_cnt;
            mask_q     <= 8'(ch_valid);
            csum       <= '0;
            idx        <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (tx.ready) begin
            tx_valid_q <= 1'b0;
            state      <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (!tx_valid_q) begin
            tx_data_q  <= seq_q;
            csum       <= csum ^ seq_q;
            tx_valid_q <= 1'b1;
          end else if (tx.ready) begin
            tx_valid_q <= 1'b0;
            state      <= ST_MASK;
          end
        end
        ST_MASK: begin
          if (!tx_valid_q) begin
            tx_data_q  <= mask_q;
            csum       <= csum ^ mask_q;
            tx_valid_q <= 1'b1;
          end else if (tx.ready) begin
            tx_valid_q <= 1'b0;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!tx_valid_q) begin
            tx_data_q  <= sr[SR_W-1 -: 8];
            csum       <= csum ^ sr[SR_W-1 -: 8];
            sr         <= sr << 8;
            tx_valid_q <= 1'b1;
          end else if (tx.ready) begin
            tx_valid_q <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= ST_CSUM;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_CSUM: begin
          if (!tx_valid_q) begin
            tx_data_q  <= csum;
            tx_valid_q <= 1'b1;
          end else if (tx.ready) begin
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer (PERIOD_CLKS=100, 2 x 16-bit channels).
module tb_telemetry_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        force_tx;
  logic [31:0] ch_data;
  logic [1:0]  ch_valid;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        overrun;

  telemetry_framer_if tx_bus ();

  telemetry_framer #(
    .PERIOD_CLKS (100),
    .N_CH        (2),
    .DATA_W      (16),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .force_tx  (force_tx),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .tx        (tx_bus),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ovr_cnt = 0;
  int         en_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] got[$];
  int         starts[$];

  logic [7:0] exp1 [8] = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'hFF, 8'h12, 8'h34, 8'hDA};
  logic [7:0] exp2 [8] = '{8'hA5, 8'h01, 8'h03, 8'h00, 8'hFF, 8'h12, 8'h34, 8'hDB};
  logic [7:0] exp3 [8] = '{8'hA5, 8'h02, 8'h03, 8'h00, 8'hFF, 8'h12, 8'h34, 8'hD8};

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor, sampled mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    if (tx_bus.valid && tx_bus.ready) got.push_back(tx_bus.data);
    if (busy && !busy_prev) starts.push_back(cyc);
    busy_prev = busy;
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] expf [8]);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got[base+i]), 32'(expf[i]));
    end
  endtask

  task automatic pulse_force();
    force_tx = 1'b1;
    step();
    force_tx = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    force_tx     = 1'b0;
    ch_data      = '0;
    ch_valid     = '0;
    tx_bus.ready = 1'b1;
    steps(3);
    check("rst_tx_data", 32'(tx_bus.data), 32'h0);
    check("rst_tx_valid", 32'(tx_bus.valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    steps(2);

    // Forced frame, ready always high.
    ch_data  = {16'h1234, 16'h00FF};
    ch_valid = 2'b11;
    got.delete();
    pulse_force();
    check("f1_busy_t1", 32'(busy), 32'd1);
    check("f1_valid_t1", 32'(tx_bus.valid), 32'd1);
    check("f1_sync_t1", 32'(tx_bus.data), 32'hA5);
    wait_idle(100);
    step();
    check("f1_len", 32'(got.size()), 32'd8);
    check_frame("f1", 0, exp1);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);

    // SYNC held for 20 clocks of backpressure.
    got.delete();
    tx_bus.ready = 1'b0;
    pulse_force();
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", 32'(tx_bus.valid), 32'd1);
      check("hold_data", 32'(tx_bus.data), 32'hA5);
      step();
    end
    check("hold_no_bytes", 32'(got.size()), 32'd0);
    tx_bus.ready = 1'b1;
    wait_idle(100);
    step();
    check("f2_len", 32'(got.size()), 32'd8);
    check_frame("f2", 0, exp2);
    check("f2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Force during DATA plus channel change mid-frame.
    got.delete();
    ovr_cnt = 0;
    pulse_force();
    for (int i = 0; i < 50 && got.size() < 4; i++) step();
    check("f3_in_data_busy", 32'(busy), 32'd1);
    ch_data = 32'hFFFF_FFFF;
    pulse_force();
    check("overrun_high", 32'(overrun), 32'd1);
    step();
    check("overrun_low", 32'(overrun), 32'd0);
    wait_idle(100);
    step();
    check_frame("f3", 0, exp3);
    check("f3_frame_cnt", 32'(frame_cnt), 32'd3);
    steps(20);
    check("f3_no_extra_frame", 32'(got.size()), 32'd8);
    check("f3_idle_after", 32'(busy), 32'd0);
    check("f3_overrun_count", 32'(ovr_cnt), 32'd1);

    // Reset while MASK is offered.
    ch_data = {16'h1234, 16'h00FF};
    got.delete();
    pulse_force();
    for (int i = 0; i < 50 && !(tx_bus.valid && got.size() == 2); i++) step();
    check("mask_offered", 32'(tx_bus.data), 32'h03);
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_bus.valid), 32'd0);
    check("arst_tx_data", 32'(tx_bus.data), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    steps(3);
    check("arst_frame_abandoned", 32'(got.size()), 32'd2);
    rst_n = 1'b1;
    step();

    // Periodic frames: 350 clocks with en=1.
    got.delete();
    starts.delete();
    en     = 1'b1;
    en_cyc = cyc;
    steps(350);
    check("per_frames", 32'(starts.size()), 32'd3);
    check("per_first_delay", 32'(starts[0] - en_cyc), 32'd100);
    check("per_gap01", 32'(starts[1] - starts[0]), 32'd100);
    check("per_gap12", 32'(starts[2] - starts[1]), 32'd100);
    check("per_bytes", 32'(got.size()), 32'd24);
    check("per_sync0", 32'(got[0]), 32'hA5);
    check("per_seq0", 32'(got[1]), 32'h00);
    check("per_seq1", 32'(got[9]), 32'h01);
    check("per_seq2", 32'(got[17]), 32'h02);
    check("per_csum0", 32'(got[7]), 32'hDA);
    en = 1'b0;
    steps(150);
    check("en_off_no_ticks", 32'(starts.size()), 32'd3);
    check("en_off_frame_cnt", 32'(frame_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
